// File: rtl/sample_feeder.sv
// -----------------------------------------------------------------------------
// sample_feeder
//
// Buffers host-written samples in a small circular FIFO and, on start, streams
// exactly POPSIZE of them to a downstream median calculator as one-cycle
// data_rdy strobes separated by GAP idle cycles. Each completed batch is
// flagged with a one-cycle batch_done pulse.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-low reset
//   wr_en       host write strobe
//   wr_data     host sample
//   full        FIFO holds DEPTH entries
//   empty       FIFO holds no entries
//   overflow    sticky: a write was attempted while full
//   start       begin a batch (honoured in IDLE only)
//   data_out    sample presented to the median calculator
//   data_rdy    one-cycle strobe, data_out valid
//   busy        a batch is in progress
//   batch_done  one-cycle pulse after the last sample of a batch
//   sent_cnt    samples sent in the current/last batch
// -----------------------------------------------------------------------------
module sample_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int POPSIZE    = 10,
   parameter int DEPTH      = 16,
   parameter int GAP        = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_en,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   output logic                           full,
   output logic                           empty,
   output logic                           overflow,
   input  logic                           start,
   output logic [DATA_WIDTH-1:0]          data_out,
   output logic                           data_rdy,
   output logic                           busy,
   output logic                           batch_done,
   output logic [$clog2(POPSIZE+1)-1:0]   sent_cnt
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int SENT_W = $clog2(POPSIZE + 1);
   localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_M1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [GAP_W-1:0]      gap_cnt;
   logic                  wr_ok;
   logic                  pop;
   logic                  last;

   // Status flags are decoded from registers only, so no input reaches them
   // combinationally. A write is judged against the registered full, so a
   // same-cycle pop never makes room for it.
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign busy  = (state != IDLE);
   assign wr_ok = wr_en && !full;
   // Pop only on a registered non-empty FIFO: a write into an empty FIFO
   // becomes visible one edge later.
   assign pop   = (state == SEND) && !empty;
   // The batch position lives in sent_cnt itself; the pop that sees
   // POPSIZE-1 already sent is the final one.
   assign last  = (sent_cnt == SENT_W'(POPSIZE - 1));

   // NOTE: the sample storage has no reset; a flush only resets pointers and
   // count, so stale contents are never observable.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // NOTE: sequential state always uses non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap naturally.
         if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (wr_en && full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: next state gets its default before the case, so no path through
   // this block leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = SEND;
         end
         SEND: begin
            // An empty FIFO simply stalls here; there is no timeout.
            if (pop) begin
               if (last)         state_nxt = DONE;
               else if (GAP > 0) state_nxt = WAIT;
               else              state_nxt = SEND;
            end
         end
         WAIT: begin
            if (gap_cnt == '0) state_nxt = SEND;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out   <= '0;
         data_rdy   <= 1'b0;
         batch_done <= 1'b0;
         sent_cnt   <= '0;
         gap_cnt    <= '0;
      end else begin
         data_rdy   <= pop;
         // The pulse follows the DONE cycle, i.e. the cycle busy drops.
         batch_done <= (state == DONE);

         if (pop) begin
            data_out <= mem[rd_ptr];
            sent_cnt <= sent_cnt + SENT_W'(1);
         end else if ((state == IDLE) && start) begin
            sent_cnt <= '0;
         end

         // Loaded on every strobe with GAP-1 so WAIT lasts exactly GAP cycles
         // and the next pop lands GAP+1 edges after the previous one.
         if (pop) begin
            gap_cnt <= GAP_LOAD;
         end else if ((state == WAIT) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_sample_feeder
//
// Self-checking bench for sample_feeder. A queue-based reference model that
// tracks the batch as "samples owed" and "earliest edge for the next strobe"
// is compared against every DUT output after every clock edge; directed
// sequences and a vector table add explicit checks on the corner cases, and
// a randomized phase closes out the run.
// -----------------------------------------------------------------------------
module tb_sample_feeder;

   localparam int DW      = 8;
   localparam int POPSIZE = 10;
   localparam int DEPTH   = 16;
   localparam int GAP     = 2;
   localparam int SW      = $clog2(POPSIZE + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic          full, empty, overflow;
   logic [DW-1:0] data_out;
   logic          data_rdy, busy, batch_done;
   logic [SW-1:0] sent_cnt;

   sample_feeder #(
      .DATA_WIDTH (DW),
      .POPSIZE    (POPSIZE),
      .DEPTH      (DEPTH),
      .GAP        (GAP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow),
      .start      (start),
      .data_out   (data_out),
      .data_rdy   (data_rdy),
      .busy       (busy),
      .batch_done (batch_done),
      .sent_cnt   (sent_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int edge_no = 0;

   // Reference model state.
   logic [DW-1:0] m_q[$];
   bit            m_active;
   int            m_sent;
   int            m_next;
   int            m_done_edge;
   bit            m_ovf;
   logic [DW-1:0] m_out;
   bit            m_rdy;
   bit            m_done;

   typedef struct {
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_out;
      int            exp_cnt;
   } vec_t;

   vec_t          nom[POPSIZE];
   logic [DW-1:0] ov[DEPTH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (edge %0d): got 0x%0h, expected 0x%0h", name, edge_no, act, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_active    = 1'b0;
      m_sent      = 0;
      m_next      = 0;
      m_done_edge = -1;
      m_ovf       = 1'b0;
      m_out       = '0;
      m_rdy       = 1'b0;
      m_done      = 1'b0;
   endtask

   // Advance the model by one rising edge using the inputs now being driven.
   task automatic model_edge();
      bit idle_pre;
      bit was_full;
      bit pop_now;
      edge_no++;
      if (!rst) begin
         model_reset();
         return;
      end
      idle_pre = !m_active;
      was_full = (m_q.size() == DEPTH);
      m_done   = m_active && (edge_no == m_done_edge);
      if (m_done) m_active = 1'b0;
      pop_now = m_active && (m_sent < POPSIZE) && (edge_no >= m_next) && (m_q.size() > 0);
      m_rdy   = pop_now;
      if (pop_now) begin
         m_out  = m_q.pop_front();
         m_sent++;
         m_next = edge_no + GAP + 1;
         if (m_sent == POPSIZE) m_done_edge = edge_no + 1;
      end
      if (wr_en) begin
         if (was_full) m_ovf = 1'b1;
         else          m_q.push_back(wr_data);
      end
      if (idle_pre && start) begin
         m_active    = 1'b1;
         m_sent      = 0;
         m_next      = edge_no + 1;
         m_done_edge = -1;
      end
   endtask

   task automatic check_outputs();
      check("m_data_rdy",   32'(data_rdy),   32'(m_rdy));
      check("m_data_out",   32'(data_out),   32'(m_out));
      check("m_batch_done", 32'(batch_done), 32'(m_done));
      check("m_busy",       32'(busy),       32'(m_active));
      check("m_sent_cnt",   32'(sent_cnt),   32'(m_sent));
      check("m_full",       32'(full),       32'(m_q.size() == DEPTH));
      check("m_empty",      32'(empty),      32'(m_q.size() == 0));
      check("m_overflow",   32'(overflow),   32'(m_ovf));
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   // Reset asserted between edges; its effect must be immediate.
   task automatic async_reset();
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs();
   endtask

   task automatic push(input logic [DW-1:0] v);
      wr_en   = 1'b1;
      wr_data = v;
      cycle();
      wr_en   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic wait_strobe(output int at, input int budget);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (data_rdy === 1'b1) begin
            at = edge_no;
            break;
         end
      end
      if (at < 0) check("strobe_timeout", 32'(data_rdy), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
      $fatal(1);
   end

   initial begin
      int at;
      int prev;

      for (int i = 0; i < POPSIZE; i++) begin
         nom[i].wdata   = DW'(i + 1);
         nom[i].exp_out = DW'(i + 1);
         nom[i].exp_cnt = i + 1;
      end

      // Reset held for 5 cycles, then released.
      model_reset();
      rst = 1'b0;
      repeat (5) cycle();
      check("rst_empty",    32'(empty),    32'd1);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_data_rdy", 32'(data_rdy), 32'd0);
      rst = 1'b1;
      repeat (2) cycle();
      check("post_rst_empty",    32'(empty),    32'd1);
      check("post_rst_data_out", 32'(data_out), 32'd0);
      check("post_rst_sent_cnt", 32'(sent_cnt), 32'd0);

      // Nominal batch from the vector table.
      for (int i = 0; i < POPSIZE; i++) push(nom[i].wdata);
      pulse_start();
      prev = edge_no;
      for (int i = 0; i < POPSIZE; i++) begin
         wait_strobe(at, 10);
         check("nom_data_out", 32'(data_out), 32'(nom[i].exp_out));
         check("nom_sent_cnt", 32'(sent_cnt), 32'(nom[i].exp_cnt));
         check("nom_spacing",  32'(at - prev), (i == 0) ? 32'd1 : 32'(GAP + 1));
         prev = at;
      end
      cycle();
      check("nom_batch_done", 32'(batch_done), 32'd1);
      check("nom_busy",       32'(busy),       32'd0);
      check("nom_empty",      32'(empty),      32'd1);
      cycle();
      check("nom_done_once",  32'(batch_done), 32'd0);
      check("nom_cnt_hold",   32'(sent_cnt),   32'(POPSIZE));

      // Stall on an empty FIFO, then one late write.
      pulse_start();
      repeat (6) begin
         cycle();
         check("stall_rdy",  32'(data_rdy), 32'd0);
         check("stall_busy", 32'(busy),     32'd1);
      end
      push(8'h5A);
      check("stall_rdy_at_write", 32'(data_rdy), 32'd0);
      cycle();
      check("stall_strobe",   32'(data_rdy), 32'd1);
      check("stall_data_out", 32'(data_out), 32'h5A);
      check("stall_busy_on",  32'(busy),     32'd1);

      // Complete that batch, with a start pulse mid-batch and one in DONE.
      for (int i = 0; i < POPSIZE - 1; i++) push(DW'(8'h60 + i));
      for (int i = 0; i < 50 && sent_cnt != SW'(4); i++) cycle();
      check("ign_pre_cnt", 32'(sent_cnt), 32'd4);
      pulse_start();
      check("ign_busy", 32'(busy), 32'd1);
      wait_strobe(at, 10);
      check("ign_cnt_continues", 32'(sent_cnt), 32'd5);
      for (int i = 0; i < 60 && sent_cnt != SW'(POPSIZE); i++) cycle();
      check("ign_final_cnt", 32'(sent_cnt), 32'(POPSIZE));
      pulse_start();
      check("done_start_batch_done", 32'(batch_done), 32'd1);
      check("done_start_busy",       32'(busy),       32'd0);
      cycle();
      check("done_start_ignored", 32'(busy),     32'd0);
      check("done_start_cnt",     32'(sent_cnt), 32'(POPSIZE));

      // Overflow: 17 writes into a 16-deep FIFO.
      for (int i = 0; i < DEPTH + 1; i++) begin
         wr_en   = 1'b1;
         wr_data = DW'($urandom);
         if (i < DEPTH) ov[i] = wr_data;
         cycle();
         if (i == DEPTH - 1) begin
            check("ovf_full_16",    32'(full),     32'd1);
            check("ovf_not_yet",    32'(overflow), 32'd0);
         end
      end
      wr_en = 1'b0;
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_full",   32'(full),     32'd1);
      pulse_start();
      for (int i = 0; i < POPSIZE; i++) begin
         wait_strobe(at, 10);
         check("ovf_batch_out", 32'(data_out), 32'(ov[i]));
      end
      repeat (2) cycle();
      check("ovf_idle",       32'(busy),     32'd0);
      check("ovf_left_queue", 32'(empty),    32'd0);
      check("ovf_still_set",  32'(overflow), 32'd1);

      // Reset mid-batch after 4 strobes drawn from the 6 left over.
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         wait_strobe(at, 10);
         check("left_out", 32'(data_out), 32'(ov[POPSIZE + i]));
      end
      check("left_nonempty", 32'(empty), 32'd0);
      async_reset();
      check("mid_rst_rdy",   32'(data_rdy), 32'd0);
      check("mid_rst_busy",  32'(busy),     32'd0);
      check("mid_rst_empty", 32'(empty),    32'd1);
      check("mid_rst_cnt",   32'(sent_cnt), 32'd0);
      check("mid_rst_ovf",   32'(overflow), 32'd0);
      cycle();
      rst = 1'b1;
      repeat (8) begin
         cycle();
         check("mid_rst_no_done", 32'(batch_done), 32'd0);
      end
      for (int i = 0; i < POPSIZE; i++) begin
         ov[i] = DW'($urandom);
         push(ov[i]);
      end
      pulse_start();
      for (int i = 0; i < POPSIZE; i++) begin
         wait_strobe(at, 10);
         check("after_rst_out", 32'(data_out), 32'(ov[i]));
      end
      cycle();
      check("after_rst_done", 32'(batch_done), 32'd1);

      // Randomized traffic against the model, with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         wr_en   = ($urandom_range(0, 99) < 40);
         wr_data = DW'($urandom);
         start   = ($urandom_range(0, 99) < 8);
         if (!rst) rst = 1'b1;
         else if ($urandom_range(0, 499) == 0) async_reset();
         cycle();
      end
      wr_en = 1'b0;
      start = 1'b0;
      rst   = 1'b1;
      repeat (3) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
